// File: rtl/job_timer_pkg.sv
// job_timer_pkg: state encoding and default widths shared by the job_timer block.
package job_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int LEN_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/job_timer_cnt.sv
// job_timer_cnt: loadable down-counter tracking the cycles a job has left to run.
module job_timer_cnt #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] remain,
    output logic         is_one
);

    always_ff @(posedge clock) begin
        if (!reset)
            remain <= '0;
        else if (load)
            remain <= load_val;
        else if (dec && remain != '0)
            remain <= remain - W'(1);
    end

    assign is_one = remain == W'(1);

endmodule

// File: rtl/job_timer.sv
// job_timer: accepts a job, pulses start, waits req_len cycles, pulses done; optional abort via JOB_TIMER_ABORT_EN.
module job_timer
    import job_timer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             start,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
`ifdef JOB_TIMER_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    state_t           state, state_n;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remain;
    logic             cnt_one;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign start     = state == START;
    assign done      = state == DONE;
    assign busy      = state != IDLE;

    job_timer_cnt #(.W(LEN_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (len_q),
        .dec      (cnt_dec),
        .remain   (remain),
        .is_one   (cnt_one)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            job_count <= '0;
        end else begin
            state <= state_n;
            if (accept)
                len_q <= req_len;
            if (state == DONE)
                job_count <= job_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE:  state_n = accept ? START : IDLE;
            START: begin
                cnt_load = 1'b1;
                state_n  = (len_q == '0) ? DONE : RUN;
            end
            // A zero remain here is unreachable; leaving RUN anyway keeps the FSM from sticking.
            RUN: begin
                cnt_dec = 1'b1;
                state_n = (cnt_one || remain == '0) ? DONE : RUN;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef JOB_TIMER_ABORT_EN
        if (abort && (state == START || state == RUN))
            state_n = DONE;
`endif
    end

`ifdef JOB_TIMER_ABORT_EN
    // Set only on the edge that enters DONE through an abort, so it lines up with that done pulse.
    always_ff @(posedge clock) begin
        if (!reset)
            aborted <= 1'b0;
        else
            aborted <= abort && (state == START || state == RUN);
    end
`endif

endmodule

// File: doc/job_timer.md
Name: job_timer

Overview:
- Upstream sequencing stage for the control FSM (`fsm`).
- Accepts job requests, each carrying a run length.
- For each job, emits a one-cycle `start` pulse, waits the programmed number of cycles, then emits a one-cycle `done` pulse.
- `start` and `done` connect directly to the FSM's `start`/`done` inputs; a completed-job counter is exported for status.

Parameters:
- LEN_W, 16, width of the request run length and of the internal down-counter.
- CNT_W, 8, width of the completed-job counter.

Ports:
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- req_valid  input  1  job request valid.
- req_len  input  LEN_W  run length of the offered job.
- req_ready  output  1  block can accept a job this cycle.
- start  output  1  one-cycle pulse at job begin.
- done  output  1  one-cycle pulse at job end.
- busy  output  1  job in progress (START, RUN or DONE).
- job_count  output  CNT_W  number of completed jobs, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, START, RUN, DONE.
- Reset (`reset`==0 at posedge):
  - state=IDLE; start=0, done=0, busy=0, job_count=0, internal remain=0.
  - req_ready is forced 0 while reset is asserted.
- Handshake:
  - req_ready = (state==IDLE) && reset deasserted.
  - Accept when req_valid && req_ready at a posedge; latch req_len and go to START.
  - req_valid without req_ready is ignored. No queueing.
- START:
  - start=1 for exactly this cycle.
  - If latched len==0, next state is DONE.
  - Otherwise load remain=len and go to RUN.
- RUN:
  - If remain==1, go to DONE; else remain<=remain-1.
- DONE:
  - done=1 for exactly this cycle; job_count<=job_count+1; next state IDLE.
- Latency:
  - Acceptance edge t → START occupies cycle t+1.
  - done is high exactly len+1 cycles after start. len=0 gives start and done on consecutive cycles.
- Outputs:
  - start, done and busy are registered decodes of state. No combinational path from req_* to any output except req_ready.
  - start and done are never high in the same cycle.
- Throughput: minimum spacing between consecutive start pulses is len+3 cycles (DONE → IDLE → accept).
- Max length: req_len=2^LEN_W-1 counts correctly; no overflow, since remain only decrements.
- job_count: wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-job: return to IDLE at the next edge; no done pulse is emitted; job_count clears.

Optional Feature:
- Macro: JOB_TIMER_ABORT_EN
- When defined:
  - Adds input port `abort` (1 bit) and output port `aborted` (1 bit).
  - abort=1 sampled in START or RUN forces next state DONE.
  - In that DONE cycle: done=1, aborted=1, and job_count increments.
  - abort is ignored in IDLE and DONE.
  - aborted resets to 0 and otherwise stays 0.
- When undefined: neither port exists; behaviour is exactly as above.

Decomposition:
- Package job_timer_pkg holds:
  - state enum typedef (IDLE, START, RUN, DONE, 2-bit encoding);
  - default width constants for LEN_W and CNT_W.
- One sub-module, job_timer_cnt: loadable down-counter.
  - Inputs: load, load value, dec.
  - Outputs: remain, is_one flag.
  - Instantiated once for remain.
- FSM and job_count stay in the top.

Test Plan:
- Reset: hold reset=0 for 16 cycles → start=0, done=0, busy=0, job_count=0, req_ready=0. After release, req_ready=1 the next cycle.
- Zero length: req_len=0 accepted at edge t → start=1 at t+1; done=1 at t+2; job_count=1; req_ready=1 at t+3.
- Length 5: accept at t → start at t+1; done at t+7; busy high t+1..t+7; req_valid held high during the job is not accepted until IDLE.
- Reset mid-job: req_len=100, assert reset 10 cycles after start → no done pulse ever; job_count=0; state IDLE; next job runs normally.
- Wrap: 256 back-to-back len=0 jobs with CNT_W=8 → job_count returns to 0; every start is followed by exactly one done.
- Abort (JOB_TIMER_ABORT_EN defined): req_len=50, abort pulsed 3 cycles after start → done and aborted both high on the next cycle; job_count=1.
